hit_flash_timer: RTL and testbench

HIT_FLASH_TIMER -- requirements
Module: hit_flash_timer

---
 rtl/hit_flash_timer.sv | 101 ++++++++++
 tb/tb_hit_flash_timer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_flash_timer.sv
// Line-clear flash effect timer: a valid hit starts or retriggers a countdown,
// with a blink pattern while active and a one-cycle done pulse on natural expiry.
module hit_flash_timer #(
  parameter int CNT_W      = 5,
  parameter int DUR1       = 3,
  parameter int DUR2       = 8,
  parameter int DUR3       = 15,
  parameter int DUR4       = 24,
  parameter int BLINK_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [2:0]       lineCount,
  input  logic             mode,
  input  logic             pause,
  output logic             hitTime,
  output logic             blink,
  output logic [2:0]       level,
  output logic [CNT_W-1:0] remaining,
  output logic             done
);

  localparam int MAX_V = (1 << CNT_W) - 1;

  // Durations longer than the counter can hold saturate instead of truncating.
  localparam logic [CNT_W-1:0] D1 = CNT_W'((DUR1 > MAX_V) ? MAX_V : DUR1);
  localparam logic [CNT_W-1:0] D2 = CNT_W'((DUR2 > MAX_V) ? MAX_V : DUR2);
  localparam logic [CNT_W-1:0] D3 = CNT_W'((DUR3 > MAX_V) ? MAX_V : DUR3);
  localparam logic [CNT_W-1:0] D4 = CNT_W'((DUR4 > MAX_V) ? MAX_V : DUR4);

  localparam int              PH_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_HALF - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] dSel;
  logic             validHit;

  // A zero selected duration covers both out-of-range line counts and DURn = 0.
  always_comb begin
    dSel = '0;
    case (lineCount)
      3'd1:    dSel = D1;
      3'd2:    dSel = D2;
      3'd3:    dSel = D3;
      3'd4:    dSel = D4;
      default: dSel = '0;
    endcase
    validHit = hit && (dSel != '0);
  end

  assign hitTime = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      level     <= '0;
      blink     <= 1'b0;
      phase     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (validHit) begin
        // A hit always wins, even on the edge the countdown would expire.
        if (state == IDLE || !mode) begin
          remaining <= dSel;
          level     <= lineCount;
        end else begin
          remaining <= (remaining > dSel) ? remaining : dSel;
          level     <= (level > lineCount) ? level : lineCount;
        end
        state <= RUN;
        blink <= 1'b1;
        phase <= '0;
      end else if (state == RUN && !pause) begin
        if (remaining == CNT_W'(1)) begin
          state     <= IDLE;
          remaining <= '0;
          level     <= '0;
          blink     <= 1'b0;
          phase     <= '0;
          done      <= 1'b1;
        end else begin
          remaining <= remaining - CNT_W'(1);
          if (phase == PH_LAST) begin
            phase <= '0;
            blink <= ~blink;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_flash_timer.sv
// Bench for hit_flash_timer: directed scenarios plus randomized traffic, all
// checked every cycle against an arithmetic model of the effect.
module tb_hit_flash_timer;

  localparam int BH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0;
  logic [2:0] lineCount = '0;
  logic       mode = 1'b0;
  logic       pause = 1'b0;

  logic       hitTime, blink, done;
  logic [2:0] level;
  logic [4:0] remaining;

  logic       sHitTime, sBlink, sDone;
  logic [2:0] sLevel;
  logic [2:0] sRem;

  int total = 0;
  int bad   = 0;
  bit compEn = 1'b0;

  logic [4:0] exp_q[$];

  int mRem = 0;
  int mLvl = 0;
  int mCnt = 0;
  bit mDone = 1'b0;

  hit_flash_timer dut (
    .clk(clk), .rst(rst), .hit(hit), .lineCount(lineCount), .mode(mode), .pause(pause),
    .hitTime(hitTime), .blink(blink), .level(level), .remaining(remaining), .done(done)
  );

  hit_flash_timer #(.CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .hit(hit), .lineCount(lineCount), .mode(mode), .pause(pause),
    .hitTime(sHitTime), .blink(sBlink), .level(sLevel), .remaining(sRem), .done(sDone)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic int dur_of(input int lc);
    case (lc)
      1: return 3;
      2: return 8;
      3: return 15;
      4: return 24;
      default: return 0;
    endcase
  endfunction

  // Behavioural model: remaining time, shown level, and count of unpaused
  // active cycles since the last load (blink is derived from that count).
  always @(posedge clk) begin
    int d;
    if (rst) begin
      mRem = 0; mLvl = 0; mCnt = 0; mDone = 1'b0;
    end else begin
      mDone = 1'b0;
      d = dur_of(int'(lineCount));
      if (d > 31) d = 31;
      if (hit && d != 0) begin
        if (mRem == 0 || !mode) begin
          mRem = d;
          mLvl = int'(lineCount);
        end else begin
          if (d > mRem) mRem = d;
          if (int'(lineCount) > mLvl) mLvl = int'(lineCount);
        end
        mCnt = 0;
      end else if (mRem > 0 && !pause) begin
        mRem = mRem - 1;
        mCnt = mCnt + 1;
        if (mRem == 0) begin
          mLvl = 0;
          mCnt = 0;
          mDone = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model vs DUT every cycle
  always @(negedge clk) begin
    if (compEn) begin
      check("m_hitTime", int'(hitTime), int'(mRem != 0));
      check("m_blink", int'(blink), int'((mRem != 0) && (((mCnt / BH) % 2) == 0)));
      check("m_level", int'(level), mLvl);
      check("m_remaining", int'(remaining), mRem);
      check("m_done", int'(done), int'(mDone));
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_hit(input int lc, input bit md);
    hit = 1'b1;
    lineCount = 3'(lc);
    mode = md;
    @(negedge clk);
    hit = 1'b0;
    lineCount = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int active;
    bit ended;

    tick(2);
    rst = 1'b0;
    compEn = 1'b1;

    // reset state
    check("rst_hitTime", int'(hitTime), 0);
    check("rst_remaining", int'(remaining), 0);
    check("rst_level", int'(level), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_done", int'(done), 0);

    // lineCount 2: 8 active cycles, blink 1,1,0,0,1,1,0,0
    pat = 8'b1100_1100;
    for (int v = 8; v >= 1; v--) exp_q.push_back(5'(v));
    do_hit(2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("d2_remaining", int'(remaining), int'(exp_q.pop_front()));
      check("d2_blink", int'(blink), int'(pat[7-i]));
      check("d2_level", int'(level), 2);
      check("d2_done_low", int'(done), 0);
      tick(1);
    end
    check("d2_end_hitTime", int'(hitTime), 0);
    check("d2_end_done", int'(done), 1);
    tick(1);
    check("d2_done_one_cycle", int'(done), 0);

    // retrigger, restart policy
    do_reset();
    do_hit(4, 1'b0);
    tick(5);
    check("rt0_before", int'(remaining), 19);
    do_hit(1, 1'b0);
    check("rt0_remaining", int'(remaining), 3);
    check("rt0_level", int'(level), 1);
    tick(2);
    check("rt0_still_on", int'(hitTime), 1);
    tick(1);
    check("rt0_off", int'(hitTime), 0);
    check("rt0_done", int'(done), 1);

    // retrigger, extend-to-max policy
    do_reset();
    do_hit(4, 1'b1);
    tick(5);
    do_hit(1, 1'b1);
    check("rt1_remaining", int'(remaining), 19);
    check("rt1_level", int'(level), 4);

    // hit on the expiry edge wins
    do_reset();
    do_hit(1, 1'b0);
    tick(2);
    check("exp_at_one", int'(remaining), 1);
    do_hit(3, 1'b0);
    check("exp_remaining", int'(remaining), 15);
    check("exp_no_done", int'(done), 0);
    check("exp_hitTime", int'(hitTime), 1);

    // pause for 4 cycles at remaining 10
    do_reset();
    do_hit(3, 1'b0);
    active = 1;
    repeat (5) begin
      tick(1);
      if (hitTime) active++;
    end
    pause = 1'b1;
    repeat (4) begin
      tick(1);
      if (hitTime) active++;
      check("pz_remaining", int'(remaining), 10);
      check("pz_blink", int'(blink), 1);
    end
    pause = 1'b0;
    ended = 1'b0;
    for (int k = 0; k < 40 && !ended; k++) begin
      tick(1);
      if (hitTime) active++;
      else ended = 1'b1;
    end
    check("pz_ended", int'(ended), 1);
    check("pz_active_total", active, 19);

    // reset mid-effect, ignored hits, first-edge acceptance
    do_reset();
    do_hit(4, 1'b0);
    tick(19);
    check("mr_at_five", int'(remaining), 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mr_hitTime", int'(hitTime), 0);
    check("mr_remaining", int'(remaining), 0);
    check("mr_level", int'(level), 0);
    check("mr_blink", int'(blink), 0);
    check("mr_done", int'(done), 0);
    do_hit(0, 1'b0);
    check("ig0_hitTime", int'(hitTime), 0);
    do_hit(6, 1'b0);
    check("ig6_hitTime", int'(hitTime), 0);
    check("ig6_remaining", int'(remaining), 0);
    do_reset();
    do_hit(2, 1'b0);
    check("first_edge_hit", int'(remaining), 8);

    // narrow counter saturates the long duration
    do_reset();
    do_hit(4, 1'b0);
    check("sat_remaining", int'(sRem), 7);
    check("sat_level", int'(sLevel), 4);
    check("sat_hitTime", int'(sHitTime), 1);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      hit = ($urandom_range(0, 7) == 0);
      lineCount = 3'($urandom_range(0, 7));
      mode = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    hit = 1'b0;
    pause = 1'b0;
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
